// File: rtl/axi_wr_master.sv
// Single-outstanding AXI4 write master: takes one command (address, beats-1), issues AW,
// streams W beats straight from din, then waits for B with a bounded response timeout.
module axi_wr_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ALEN_WIDTH = 8,
  parameter int unsigned B_TIMEOUT  = 256
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ALEN_WIDTH-1:0]   cmd_len,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DATA_WIDTH-1:0]   din_data,
  input  logic [DATA_WIDTH/8-1:0] din_strb,
  output logic                    awvalid,
  input  logic                    awready,
  output logic                    awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [ALEN_WIDTH-1:0]   awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  input  logic [1:0]              bresp,
  output logic                    bready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    timeout
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SIZE_VAL   = $clog2(STRB_WIDTH);
  localparam int unsigned TO_WIDTH   = (B_TIMEOUT > 1) ? $clog2(B_TIMEOUT) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(B_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ALEN_WIDTH-1:0]   len_q, len_d;
  logic [ALEN_WIDTH-1:0]   beat_q, beat_d;
  logic [TO_WIDTH-1:0]     to_q, to_d;
  logic                    done_d, err_d, timeout_d;

  // AW channel fields are constant or come from the latched command, so they are stable until awready
  assign awid    = 1'b0;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = 3'(SIZE_VAL);
  assign awburst = 2'b01;
  assign wdata   = din_data;
  assign wstrb   = din_strb;

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      to_q    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      done    <= done_d;
      err     <= err_d;
      timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    to_d      = to_q;
    done_d    = 1'b0;
    err_d     = err;
    timeout_d = timeout;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    din_ready = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    busy      = 1'b1;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          state_d = ADDR;
        end
      end
      ADDR: begin
        awvalid = 1'b1;
        if (awready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        wvalid    = din_valid;
        din_ready = wready;
        // Equality compare: the 2^ALEN_WIDTH-beat case never needs the wrapped value
        wlast     = (beat_q == len_q);
        if (din_valid && wready) begin
          beat_d = beat_q + ALEN_WIDTH'(1);
          if (wlast) begin
            to_d    = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        bready = 1'b1;
        // A response arriving on the expiry cycle takes priority over the timeout
        if (bvalid) begin
          done_d    = 1'b1;
          err_d     = (bresp != 2'b00);
          timeout_d = 1'b0;
          state_d   = IDLE;
        end else if (to_q == TO_LIMIT) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/axi_wr_master.md
AXI_WR_MASTER -- requirements
Module: axi_wr_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning AXI data width (multiple of 8).
REQ-003 The block SHALL have parameter ALEN_WIDTH, default 8, meaning AXI burst length field width.
REQ-004 The block SHALL have parameter B_TIMEOUT, default 256, meaning max cycles waiting for BVALID (minimum 1).
REQ-005 The block SHALL have ports: clk, input, 1, the single clock.
REQ-006 arst, input, 1, synchronous active-high reset.
REQ-007 cmd_valid/cmd_ready, input/output, 1/1, command handshake.
REQ-008 cmd_addr/cmd_len, input, ADDR_WIDTH/ALEN_WIDTH, start address and beats-minus-one.
REQ-009 din_valid/din_ready, input/output, 1/1, write-data stream handshake.
REQ-010 din_data/din_strb, input, DATA_WIDTH/DATA_WIDTH/8, beat payload and byte strobes.
REQ-011 awvalid/awready, output/input, 1/1; awid output 1; awaddr output ADDR_WIDTH; awlen output ALEN_WIDTH; awsize output 3; awburst output 2.
REQ-012 wvalid/wready, output/input, 1/1; wdata output DATA_WIDTH; wstrb output DATA_WIDTH/8; wlast output 1.
REQ-013 bvalid input 1; bresp input 2; bready output 1.
REQ-014 busy output 1; done output 1 (one-cycle pulse); err output 1; timeout output 1, valid while done=1.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, DATA, RESP; one transaction in flight at a time.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch cmd_addr, cmd_len, go ADDR next cycle.
REQ-017 ADDR: awvalid=1, awaddr/awlen from latched values, awid=0, awsize=log2(DATA_WIDTH/8), awburst=INCR (2'b01); AW fields SHALL stay stable until awready; on awvalid&awready go DATA.
REQ-018 W beats SHALL NOT be issued before the AW handshake completes.
REQ-019 DATA: wvalid=din_valid, din_ready=wready, wdata=din_data, wstrb=din_strb (combinational pass-through, zero added latency).
REQ-020 Beat counter (ALEN_WIDTH bits) SHALL clear on entry to DATA and increment on each wvalid&wready.
REQ-021 wlast SHALL be 1 exactly when counter==latched len; len=0 gives single beat with wlast=1; len=2^ALEN_WIDTH-1 gives 2^ALEN_WIDTH beats without counter overflow affecting wlast.
REQ-022 On the wlast beat handshake go RESP.
REQ-023 RESP: bready=1; timeout counter clears on entry, increments each cycle bvalid=0.
REQ-024 bvalid&bready: done=1 next cycle, err=(bresp!=2'b00), timeout=0, return IDLE.
REQ-025 Counter reaching B_TIMEOUT-1 without bvalid: done=1, err=1, timeout=1, return IDLE.
REQ-026 bvalid and timeout expiry in the same cycle: the response SHALL win (timeout=0).
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Outside their states awvalid, wvalid, wlast, bready, din_ready SHALL be 0; cmd_ready SHALL be 0 outside IDLE.
REQ-029 A new command SHALL be accepted in the cycle after done (back-to-back allowed).
REQ-030 err and timeout SHALL hold their value until the next done pulse.

Reset
REQ-031 On arst sampled high at a clk edge: state=IDLE, all counters=0, busy=0, done=0, err=0, timeout=0, awvalid=wvalid=bready=0, cmd_ready=1 after release.
REQ-032 Reset mid-transaction SHALL abandon it immediately with no done pulse; din is not drained.

Verification
REQ-033 cmd addr=0x1000 len=3, awready/wready always 1, bresp=0 -> awaddr=0x1000 awlen=3, 4 W beats, wlast on 4th only, done=1 err=0.
REQ-034 len=0, awready delayed 5 cycles -> AW stable 6 cycles, no W before AW handshake, single beat wlast=1.
REQ-035 len=7, wready toggled randomly, din_valid gaps -> exactly 8 beats, data order preserved, wlast on 8th.
REQ-036 bresp=2'b10 (SLVERR) -> done=1 err=1 timeout=0; next cmd accepted the following cycle.
REQ-037 B_TIMEOUT=16, bvalid never asserted -> done at RESP entry+16, err=1 timeout=1; bvalid coincident with expiry -> timeout=0.
REQ-038 arst asserted during DATA beat 2 of 4 -> next cycle IDLE, all outputs at reset values, no done pulse.
